// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide unit: iterative shift-add multiplier and restoring
// divider sharing one working register pair, plus direct HI/LO moves.
module hilo_muldiv_unit #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MSUB  = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             sgn_q, sgn_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] wh_q, wh_d;
  logic [WIDTH-1:0] wl_q, wl_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic             in_sgn;
  logic [WIDTH-1:0] in_mag_a, in_mag_b;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [2*WIDTH-1:0] prod_mag, prod_val, acc_val, res_val;
  logic [WIDTH-1:0] quo_val, rem_val;

  assign Busy      = (state_q != IDLE);
  assign Done      = done_q;
  assign DivByZero = dbz_q;
  assign HI        = hi_q;
  assign LO        = lo_q;

  // Operand magnitudes and one step of each iterative datapath
  always_comb begin
    in_sgn    = SIGNED_EN && ((Op == OP_MULT) || (Op == OP_DIV) ||
                              (Op == OP_MADD) || (Op == OP_MSUB));
    in_mag_a  = (in_sgn && A[WIDTH-1]) ? -A : A;
    in_mag_b  = (in_sgn && B[WIDTH-1]) ? -B : B;
    a_neg     = sgn_q && a_q[WIDTH-1];
    b_neg     = sgn_q && b_q[WIDTH-1];
    mag_a     = a_neg ? -a_q : a_q;
    mag_b     = b_neg ? -b_q : b_q;
    mul_sum   = {1'b0, wh_q} + {1'b0, (wl_q[0] ? mag_a : '0)};
    div_shift = {wh_q, wl_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, mag_b});
    div_diff  = div_shift[WIDTH-1:0] - mag_b;
    prod_mag  = {wh_q, wl_q};
    prod_val  = (a_neg ^ b_neg) ? -prod_mag : prod_mag;
    acc_val   = {hi_q, lo_q};
    case (op_q)
      OP_MADD: res_val = acc_val + prod_val;
      OP_MSUB: res_val = acc_val - prod_val;
      default: res_val = prod_val;
    endcase
    quo_val   = (a_neg ^ b_neg) ? -wl_q : wl_q;
    rem_val   = a_neg ? -wh_q : wh_q;
  end

  // Next-state and register-update logic for the sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sgn_d   = sgn_q;
    a_d     = a_q;
    b_d     = b_q;
    wh_d    = wh_q;
    wl_d    = wl_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start && !Flush) begin
          dbz_d = 1'b0;
          op_d  = Op;
          sgn_d = in_sgn;
          a_d   = A;
          b_d   = B;
          cnt_d = '0;
          case (Op)
            OP_MTHI: begin
              hi_d   = A;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = A;
              done_d = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              state_d = DIV;
              wh_d    = '0;
              wl_d    = in_mag_a;
            end
            default: begin
              state_d = MUL;
              wh_d    = '0;
              wl_d    = in_mag_b;
            end
          endcase
        end
      end
      MUL: begin
        wh_d  = mul_sum[WIDTH:1];
        wl_d  = {mul_sum[0], wl_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = FIX;
      end
      DIV: begin
        wh_d  = div_ge ? div_diff : div_shift[WIDTH-1:0];
        wl_d  = {wl_q[WIDTH-2:0], div_ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if ((op_q == OP_DIV) || (op_q == OP_DIVU)) begin
          if (b_q == '0) begin
            hi_d  = a_q;
            lo_d  = '1;
            dbz_d = 1'b1;
          end else begin
            hi_d = rem_val;
            lo_d = quo_val;
          end
        end else begin
          {hi_d, lo_d} = res_val;
        end
      end
      default: state_d = IDLE;
    endcase
    if (Flush && (state_q != IDLE)) begin
      state_d = IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = dbz_q;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sgn_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      wh_q    <= '0;
      wl_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sgn_q   <= sgn_d;
      a_q     <= a_d;
      b_q     <= b_d;
      wh_q    <= wh_d;
      wl_q    <= wl_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Randomized self-checking bench for hilo_muldiv_unit against an arithmetic
// reference model of HI/LO, plus directed scenarios for flush and reset.
module tb_hilo_muldiv_unit;

  localparam int W = 32;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Start;
  logic [2:0]    Op;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          Flush;
  logic          Busy;
  logic          Done;
  logic          DivByZero;
  logic [W-1:0]  HI;
  logic [W-1:0]  LO;

  int checkCount = 0;
  int errorCount = 0;

  logic [W-1:0] mHi;
  logic [W-1:0] mLo;
  logic         mDbz;

  hilo_muldiv_unit #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Flush(Flush), .Busy(Busy), .Done(Done), .DivByZero(DivByZero),
    .HI(HI), .LO(LO)
  );

  // Free-running clock
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Architectural effect of one completed operation, in plain arithmetic
  task automatic modelOp(input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    longint sa, sb, q, r;
    bit sgn;
    sgn  = (op == 3'd0) || (op == 3'd2) || (op == 3'd4) || (op == 3'd5);
    sa   = sgn ? longint'($signed(a)) : longint'(a);
    sb   = sgn ? longint'($signed(b)) : longint'(b);
    mDbz = 1'b0;
    case (op)
      3'd0, 3'd1: {mHi, mLo} = 64'(sa * sb);
      3'd4:       {mHi, mLo} = {mHi, mLo} + 64'(sa * sb);
      3'd5:       {mHi, mLo} = {mHi, mLo} - 64'(sa * sb);
      3'd2, 3'd3: begin
        if (b == '0) begin
          mHi  = a;
          mLo  = '1;
          mDbz = 1'b1;
        end else begin
          q   = sa / sb;
          r   = sa % sb;
          mLo = 32'(q);
          mHi = 32'(r);
        end
      end
      3'd6:    mHi = a;
      default: mLo = a;
    endcase
  endtask

  // Issue one operation, wait for completion and compare against the model
  task automatic applyStimulus(input string tag, input logic [2:0] op,
                               input logic [W-1:0] a, input logic [W-1:0] b);
    int busyCycles;
    int expBusy;
    @(negedge Clk);
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    @(negedge Clk);
    Start = 1'b0;
    A     = $urandom;
    B     = $urandom;
    modelOp(op, a, b);
    expBusy    = (op >= 3'd6) ? 0 : W + 1;
    busyCycles = 0;
    while (Busy && busyCycles < 200) begin
      busyCycles++;
      @(negedge Clk);
    end
    checkOutput({tag, " busy"}, 64'(busyCycles), 64'(expBusy));
    checkOutput({tag, " done"}, 64'(Done), 64'd1);
    checkOutput({tag, " hi"}, 64'(HI), 64'(mHi));
    checkOutput({tag, " lo"}, 64'(LO), 64'(mLo));
    checkOutput({tag, " dbz"}, 64'(DivByZero), 64'(mDbz));
    @(negedge Clk);
    checkOutput({tag, " done off"}, 64'(Done), 64'd0);
    checkOutput({tag, " hilo hold"}, {HI, LO}, {mHi, mLo});
  endtask

  function automatic logic [W-1:0] pickVal();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'd1;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Main sequence: reset, directed cases, flush/reset scenarios, random ops
  initial begin
    int doneSeen;
    Reset = 1'b1;
    Start = 1'b0;
    Flush = 1'b0;
    Op    = '0;
    A     = '0;
    B     = '0;
    mHi   = '0;
    mLo   = '0;
    mDbz  = 1'b0;
    repeat (2) @(negedge Clk);
    checkOutput("reset hi", 64'(HI), 64'd0);
    checkOutput("reset lo", 64'(LO), 64'd0);
    checkOutput("reset busy", 64'(Busy), 64'd0);
    checkOutput("reset done", 64'(Done), 64'd0);
    checkOutput("reset dbz", 64'(DivByZero), 64'd0);
    Reset = 1'b0;

    applyStimulus("mult neg", 3'd0, 32'hFFFF_FFFD, 32'd7);
    checkOutput("mult neg const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);
    applyStimulus("divu", 3'd3, 32'd100, 32'd7);
    checkOutput("divu const", {HI, LO}, {32'd2, 32'd14});
    applyStimulus("div neg", 3'd2, 32'hFFFF_FFF9, 32'd2);
    checkOutput("div neg const", {HI, LO}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    applyStimulus("div ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    checkOutput("div ovf const", {HI, LO}, {32'd0, 32'h8000_0000});
    applyStimulus("div zero", 3'd2, 32'd5, 32'd0);
    checkOutput("div zero const", {HI, LO}, {32'd5, 32'hFFFF_FFFF});
    checkOutput("div zero flag", 64'(DivByZero), 64'd1);
    applyStimulus("mtlo clr", 3'd7, 32'd1, 32'd0);
    checkOutput("mtlo clr flag", 64'(DivByZero), 64'd0);
    applyStimulus("mthi", 3'd6, 32'd0, 32'd0);
    applyStimulus("mtlo", 3'd7, 32'd10, 32'd0);
    applyStimulus("madd", 3'd4, 32'd3, 32'd4);
    checkOutput("madd const", {HI, LO}, {32'd0, 32'd22});
    applyStimulus("msub", 3'd5, 32'd2, 32'd11);
    checkOutput("msub const", {HI, LO}, 64'd0);

    // Flush and Start together in IDLE: the start is dropped
    @(negedge Clk);
    Start = 1'b1;
    Flush = 1'b1;
    Op    = 3'd6;
    A     = 32'hABCD_0123;
    @(negedge Clk);
    Start = 1'b0;
    Flush = 1'b0;
    checkOutput("idle flush busy", 64'(Busy), 64'd0);
    checkOutput("idle flush done", 64'(Done), 64'd0);
    checkOutput("idle flush hi", 64'(HI), 64'(mHi));

    // MULT with an ignored second start, then flushed mid-flight
    applyStimulus("mthi pre", 3'd6, 32'h1111_2222, 32'd0);
    applyStimulus("div pre", 3'd2, 32'd9, 32'd0);
    @(negedge Clk);
    Start = 1'b1;
    Op    = 3'd0;
    A     = 32'd1234;
    B     = 32'd5678;
    @(negedge Clk);
    Start = 1'b0;
    mDbz  = 1'b0;
    repeat (4) @(negedge Clk);
    Start = 1'b1;
    Op    = 3'd6;
    A     = 32'hDEAD_BEEF;
    @(negedge Clk);
    Start = 1'b0;
    checkOutput("flush busy mid", 64'(Busy), 64'd1);
    repeat (4) @(negedge Clk);
    Flush = 1'b1;
    @(negedge Clk);
    Flush = 1'b0;
    checkOutput("flush busy", 64'(Busy), 64'd0);
    checkOutput("flush hilo", {HI, LO}, {mHi, mLo});
    checkOutput("flush dbz", 64'(DivByZero), 64'(mDbz));
    doneSeen = 0;
    repeat (40) begin
      if (Done) doneSeen++;
      @(negedge Clk);
    end
    checkOutput("flush no done", 64'(doneSeen), 64'd0);
    checkOutput("flush hilo later", {HI, LO}, {mHi, mLo});

    // Reset in the middle of a divide
    applyStimulus("mthi rst", 3'd6, 32'h0000_1234, 32'd0);
    applyStimulus("mtlo rst", 3'd7, 32'h0000_5678, 32'd0);
    @(negedge Clk);
    Start = 1'b1;
    Op    = 3'd2;
    A     = 32'd1000;
    B     = 32'd3;
    @(negedge Clk);
    Start = 1'b0;
    repeat (5) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    mHi   = '0;
    mLo   = '0;
    mDbz  = 1'b0;
    checkOutput("rst mid hilo", {HI, LO}, 64'd0);
    checkOutput("rst mid busy", 64'(Busy), 64'd0);
    checkOutput("rst mid dbz", 64'(DivByZero), 64'd0);
    doneSeen = 0;
    repeat (40) begin
      if (Done) doneSeen++;
      @(negedge Clk);
    end
    checkOutput("rst mid no done", 64'(doneSeen), 64'd0);

    // Randomized operations
    for (int i = 0; i < 60; i++) begin
      logic [2:0]   rop;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      rop = 3'($urandom_range(0, 7));
      ra  = pickVal();
      rb  = pickVal();
      applyStimulus($sformatf("rand%0d op%0d", i, rop), rop, ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
